rf_mul_seq: RTL and testbench

Sequential 32×32 multiplier stage that sits next to the 32-entry, 2-read/1-write register file and operates on it directly. It accepts a command naming two source registers and one destination register. It reads both operands through the register file's read ports, then runs a 32-iteration shift-add multiply. It writes the low product word back through the register file's write port. The high product word is held in a local result register for inspection.

---
 rtl/rf_mul_seq_if.sv | 31 +++
 rtl/rf_mul_seq.sv | 154 +++++++++++++++
 tb/tb_rf_mul_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_mul_seq_if.sv
// rf_mul_seq_if: command handshake plus register-file port bundle for rf_mul_seq.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_valid may be held across busy periods, and
// cmd_rs/cmd_rt/cmd_rd/cmd_signed only matter on the transfer edge.
interface rf_mul_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic        cmd_signed;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Requester side: issues commands and serves the register file ports.
  modport master (
    output cmd_valid, cmd_rs, cmd_rt, cmd_rd, cmd_signed, rf_rdata1, rf_rdata2,
    input  cmd_ready, rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata
  );

  // Multiplier side.
  modport slave (
    input  cmd_valid, cmd_rs, cmd_rt, cmd_rd, cmd_signed, rf_rdata1, rf_rdata2,
    output cmd_ready, rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_mul_seq.sv
// rf_mul_seq: sequential 32x32 shift-add multiplier working directly on a
// 2R/1W register file. Reads rs/rt, runs 32 iterations, writes the low
// product word to rd and keeps the high word in result_hi.
// Optional feature macro: RF_MUL_SIGNED_EN enables two's-complement mode via
// cmd_signed (sign/magnitude on entry, negation on exit); without it every
// multiply is unsigned and latency is identical.
module rf_mul_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  rf_mul_seq_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [31:0] mcand;
  logic [31:0] mlier;
  logic [63:0] acc;
  logic [63:0] addend;
  logic [63:0] acc_sum;
  logic [63:0] product;
  logic [4:0]  cnt;
  logic        last_iter;

`ifdef RF_MUL_SIGNED_EN
  logic        signed_q;
  logic        neg_q;
`else
  logic        unused_signed;
  assign unused_signed = bus.cmd_signed;
`endif

  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.rf_raddr1 = rs_q;
  assign bus.rf_raddr2 = rt_q;
  assign state_dbg     = state;
  assign last_iter     = (cnt == 5'(ITER - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next    = state;
    bus.cmd_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
        if (bus.cmd_valid) state_next = READ;
      end
      READ: state_next = MUL;
      MUL:  if (last_iter) state_next = WB;
      WB: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One shift-add step; on the final step the sign fix-up is folded in so the
  // write-back registers load the finished product.
  always_comb begin
    addend  = mlier[0] ? ({32'b0, mcand} << cnt) : 64'b0;
    acc_sum = acc + addend;
    product = acc_sum;
`ifdef RF_MUL_SIGNED_EN
    if (neg_q) product = -acc_sum;
`endif
  end

  // Command capture, operand load, iteration datapath and registered write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      mcand        <= '0;
      mlier        <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.rf_wen   <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      result_hi    <= '0;
`ifdef RF_MUL_SIGNED_EN
      signed_q     <= 1'b0;
      neg_q        <= 1'b0;
`endif
    end else begin
      bus.rf_wen <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rs_q     <= bus.cmd_rs;
            rt_q     <= bus.cmd_rt;
            rd_q     <= bus.cmd_rd;
`ifdef RF_MUL_SIGNED_EN
            signed_q <= bus.cmd_signed;
`endif
          end
        end
        READ: begin
          acc <= '0;
          cnt <= '0;
`ifdef RF_MUL_SIGNED_EN
          // -2^31 negates to itself, which is the correct unsigned magnitude.
          mcand <= (signed_q && bus.rf_rdata1[31]) ? -bus.rf_rdata1 : bus.rf_rdata1;
          mlier <= (signed_q && bus.rf_rdata2[31]) ? -bus.rf_rdata2 : bus.rf_rdata2;
          neg_q <= signed_q && (bus.rf_rdata1[31] ^ bus.rf_rdata2[31]);
`else
          mcand <= bus.rf_rdata1;
          mlier <= bus.rf_rdata2;
`endif
        end
        MUL: begin
          acc   <= acc_sum;
          mlier <= mlier >> 1;
          cnt   <= cnt + 5'd1;
          if (last_iter) begin
            bus.rf_wen   <= (rd_q != 5'd0);
            bus.rf_waddr <= rd_q;
            bus.rf_wdata <= product[31:0];
            result_hi    <= product[63:32];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_mul_seq.sv
// tb_rf_mul_seq: directed bench for rf_mul_seq with a register-file model,
// driver tasks, an expected-result queue and a monitor that checks every
// write-back cycle.
module tb_rf_mul_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_mul_seq_if bus();
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [1:0]  state_dbg;

  rf_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .state_dbg (state_dbg)
  );

`ifdef RF_MUL_SIGNED_EN
  localparam logic [31:0] NEG3_X7_HI    = 32'hFFFFFFFF;
  localparam logic [31:0] MIN_X1_HI     = 32'hFFFFFFFF;
`else
  localparam logic [31:0] NEG3_X7_HI    = 32'h00000006;
  localparam logic [31:0] MIN_X1_HI     = 32'h00000000;
`endif

  // ---------------- register file model ----------------
  logic [31:0] regs [32];
  logic        pl_en   = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  initial for (int i = 0; i < 32; i++) regs[i] = '0;

  always @(posedge clk) begin
    if (pl_en) regs[pl_addr] <= pl_data;
    else if (bus.rf_wen && bus.rf_waddr != 5'd0) regs[bus.rf_waddr] <= bus.rf_wdata;
  end

  assign bus.rf_rdata1 = (bus.rf_raddr1 == 5'd0) ? 32'd0 : regs[bus.rf_raddr1];
  assign bus.rf_rdata2 = (bus.rf_raddr2 == 5'd0) ? 32'd0 : regs[bus.rf_raddr2];

  // ---------------- scoreboard state ----------------
  logic [69:0] exp_q[$];   // {wen, waddr, wdata, result_hi}
  int          acc_q[$];   // edge index of each accept
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [69:0] e;
    int          a;
    @(negedge clk);
    if (!rst && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc + 1);
    if (bus.rf_wen) check("wen_only_in_wb", {63'b0, done}, 64'd1);
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_without_cmd", {63'b0, done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_wen",       {63'b0, bus.rf_wen},   {63'b0, e[69]});
        check("wb_waddr",     {59'b0, bus.rf_waddr}, {59'b0, e[68:64]});
        check("wb_wdata",     {32'b0, bus.rf_wdata}, {32'b0, e[63:32]});
        check("wb_result_hi", {32'b0, result_hi},    {32'b0, e[31:0]});
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          check("wb_latency", 64'(cyc - a), 64'd33);
        end
      end
    end
  end

  // ---------------- driver tasks (entered/left just after a rising edge) ----------------
  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic sgn, input logic [31:0] lo, input logic [31:0] hi,
                       input logic expect_wb);
    int n;
    bus.cmd_valid  = 1'b1;
    bus.cmd_rs     = rs;
    bus.cmd_rt     = rt;
    bus.cmd_rd     = rd;
    bus.cmd_signed = sgn;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 100);
    if (!bus.cmd_ready) check("accept_timeout", {63'b0, bus.cmd_ready}, 64'd1);
    if (expect_wb) exp_q.push_back({(rd != 5'd0), rd, lo, hi});
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_rs     = 5'($urandom_range(0, 31));
    bus.cmd_rt     = 5'($urandom_range(0, 31));
    bus.cmd_rd     = 5'($urandom_range(0, 31));
    bus.cmd_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, {63'b0, bus.cmd_ready}, 64'd1);
    check({tag, "_busy"},      {63'b0, busy},          64'd0);
    check({tag, "_done"},      {63'b0, done},          64'd0);
    check({tag, "_rf_wen"},    {63'b0, bus.rf_wen},    64'd0);
    check({tag, "_rf_waddr"},  {59'b0, bus.rf_waddr},  64'd0);
    check({tag, "_rf_wdata"},  {32'b0, bus.rf_wdata},  64'd0);
    check({tag, "_rf_raddr1"}, {59'b0, bus.rf_raddr1}, 64'd0);
    check({tag, "_rf_raddr2"}, {59'b0, bus.rf_raddr2}, 64'd0);
    check({tag, "_result_hi"}, {32'b0, result_hi},     64'd0);
    check({tag, "_state"},     {62'b0, state_dbg},     64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int a1;
    int a2;
    int acc_cnt;
    bus.cmd_valid  = 1'b0;
    bus.cmd_rs     = '0;
    bus.cmd_rt     = '0;
    bus.cmd_rd     = '0;
    bus.cmd_signed = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 0x3F * 0x3 = 0xBD
    preload(5'd5, 32'h0000003F);
    preload(5'd6, 32'h00000003);
    issue(5'd5, 5'd6, 5'd7, 1'b0, 32'h000000BD, 32'h0, 1'b1);
    drain();
    check("r7_after_wb", {32'b0, regs[7]}, 64'h0BD);

    // Largest unsigned operands.
    preload(5'd1, 32'hFFFFFFFF);
    preload(5'd2, 32'hFFFFFFFF);
    issue(5'd1, 5'd2, 5'd3, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    drain();

    // -3 * 7, signed request, then the same operands as unsigned.
    preload(5'd1, 32'hFFFFFFFD);
    preload(5'd2, 32'h00000007);
    issue(5'd1, 5'd2, 5'd4, 1'b1, 32'hFFFFFFEB, NEG3_X7_HI, 1'b1);
    drain();
    issue(5'd1, 5'd2, 5'd11, 1'b0, 32'hFFFFFFEB, 32'h00000006, 1'b1);
    drain();

    // -2^31 * 1, signed request.
    preload(5'd8, 32'h80000000);
    preload(5'd9, 32'h00000001);
    issue(5'd8, 5'd9, 5'd10, 1'b1, 32'h80000000, MIN_X1_HI, 1'b1);
    drain();

    // rd = 0: done pulses, no write; 0x3F * 0x3F = 0xF81.
    issue(5'd5, 5'd5, 5'd0, 1'b0, 32'h00000F81, 32'h0, 1'b1);
    drain();

    // Reset while the multiply is in flight: nothing may be written.
    issue(5'd5, 5'd6, 5'd12, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    acc_q.delete();
    repeat (40) @(posedge clk);
    #1;
    check("abort_r12_untouched", {32'b0, regs[12]}, 64'd0);

    // cmd_valid held: r5 = 3 -> 9 -> 81, accepts 35 cycles apart.
    preload(5'd5, 32'h00000003);
    exp_q.push_back({1'b1, 5'd5, 32'd9,  32'd0});
    exp_q.push_back({1'b1, 5'd5, 32'd81, 32'd0});
    bus.cmd_valid  = 1'b1;
    bus.cmd_rs     = 5'd5;
    bus.cmd_rt     = 5'd5;
    bus.cmd_rd     = 5'd5;
    bus.cmd_signed = 1'b0;
    acc_cnt = 0;
    a1 = 0;
    a2 = 0;
    n = 0;
    while (acc_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.cmd_ready) begin
        acc_cnt++;
        if (acc_cnt == 1) a1 = cyc + 1;
        else              a2 = cyc + 1;
      end
    end
    if (acc_cnt < 2) check("b2b_accept_timeout", 64'(acc_cnt), 64'd2);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("b2b_spacing", 64'(a2 - a1), 64'd35);
    drain();
    check("b2b_r5_final", {32'b0, regs[5]}, 64'd81);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
